// File: rtl/dmem_responder_if.sv
// Data-bus side of the MEM-stage responder.
// Single outstanding req/ack transaction with wait states.
interface dmem_responder_if;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [3:0]  memBe;
  logic [31:0] memRdata;
  logic        memAck;

  modport master (
    output memReq,
    output memWe,
    output memAddr,
    output memWdata,
    output memBe,
    input  memRdata,
    input  memAck
  );

  modport slave (
    input  memReq,
    input  memWe,
    input  memAddr,
    input  memWdata,
    input  memBe,
    output memRdata,
    output memAck
  );
endinterface

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one bus transaction per request,
// with a wait-state timeout that forces an error response.
module dmem_responder #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dataAddr,
  input  logic [31:0] dataOut,
  input  logic [3:0]  dataMask,
  input  logic        dataWe,
  input  logic        dataRe,
  output logic [31:0] dataIn,
  output logic        memValid,
  output logic        busErr,
  dmem_responder_if.master bus
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_req;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic w_req;
  logic w_to;

  assign w_req = dataWe | dataRe;
  assign w_to  = (TIMEOUT != 0) && (r_cnt == LAST);

  // IDLE releases the stage combinationally when nothing is requested
  assign memValid = (r_state == IDLE) ? ~w_req
                                      : (r_state == DONE);
  assign dataIn   = r_rdata;
  assign busErr   = r_err;

  assign bus.memReq   = r_req;
  assign bus.memWe    = r_we;
  assign bus.memAddr  = r_addr;
  assign bus.memWdata = r_wdata;
  assign bus.memBe    = r_be;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_state <= BUS;
            r_req   <= 1'b1;
            r_we    <= dataWe;
            r_addr  <= {dataAddr[31:2], 2'b00};
            r_wdata <= dataOut;
            r_be    <= dataWe ? dataMask : 4'hF;
            r_cnt   <= '0;
          end
        end
        BUS: begin
          // ack takes priority over a coinciding timeout
          if (bus.memAck) begin
            r_state <= DONE;
            r_req   <= 1'b0;
            r_rdata <= r_we ? 32'h0 : bus.memRdata;
          end else if (w_to) begin
            r_state <= DONE;
            r_req   <= 1'b0;
            r_rdata <= r_we ? 32'h0 : ERR_DATA;
            r_err   <= 1'b1;
          end else if (r_cnt != {CW{1'b1}}) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_err   <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver queues expected
// responses, a negedge monitor checks bus fields and completions.
module tb_dmem_responder;

  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk;
  logic        rst;
  logic [31:0] dataAddr;
  logic [31:0] dataOut;
  logic [3:0]  dataMask;
  logic        dataWe;
  logic        dataRe;
  logic [31:0] dataIn;
  logic        memValid;
  logic        busErr;

  dmem_responder_if bus ();

  dmem_responder #(
    .TIMEOUT  (TO),
    .ERR_DATA (ERR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .dataAddr (dataAddr),
    .dataOut  (dataOut),
    .dataMask (dataMask),
    .dataWe   (dataWe),
    .dataRe   (dataRe),
    .dataIn   (dataIn),
    .memValid (memValid),
    .busErr   (busErr),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          lat;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cnt     = 0;
  int reqc    = 0;

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // Reference: ack in BUS cycle waits+1 is in time if waits < TO
  task automatic txn(input logic we, input logic re,
                     input logic [31:0] addr,
                     input logic [31:0] wd,
                     input logic [3:0] mk,
                     input int waits,
                     input logic [31:0] rd);
    exp_t e;
    bit   to;
    bit   done;
    to      = (waits >= TO);
    e.addr  = addr & 32'hFFFF_FFFC;
    e.be    = we ? mk : 4'hF;
    e.we    = we;
    e.wdata = wd;
    e.err   = to;
    e.data  = we ? 32'h0 : (to ? ERR : rd);
    e.lat   = 2 + (to ? TO - 1 : waits);
    q.push_back(e);
    @(posedge clk); #1;
    dataWe   = we;
    dataRe   = re;
    dataAddr = addr;
    dataOut  = wd;
    dataMask = mk;
    done     = 0;
    for (int c = 1; c < 60; c++) begin
      @(posedge clk); #1;
      if (memValid) begin
        bus.memAck = 1'b0;
        done = 1;
        break;
      end
      bus.memAck   = (c == waits + 1);
      bus.memRdata = bus.memAck ? rd : $urandom;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL txn_bound: got no memValid expected completion");
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    dataWe = 1'b0;
    dataRe = 1'b0;
    bus.memAck = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor
  logic mreq;
  always @(negedge clk) begin
    if (!rst) begin
      cnt  = 0;
      reqc = 0;
    end else begin
      mreq = dataWe | dataRe;
      if (!mreq) begin
        chk("idle_valid", {31'b0, memValid}, 32'd1);
        chk("idle_req", {31'b0, bus.memReq}, 32'd0);
      end
      chk("busErr_outside_done",
          {31'b0, busErr & ~(mreq & memValid)}, 32'd0);
      if (bus.memReq) reqc++;
      if (bus.memReq && q.size() > 0) begin
        chk("bus_addr", bus.memAddr, q[0].addr);
        chk("bus_be", {28'b0, bus.memBe}, {28'b0, q[0].be});
        chk("bus_we", {31'b0, bus.memWe}, {31'b0, q[0].we});
        chk("bus_wdata", bus.memWdata, q[0].wdata);
      end
      if (mreq && !memValid) begin
        cnt++;
      end else if (mreq && memValid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("dataIn", dataIn, e.data);
          chk("busErr", {31'b0, busErr}, {31'b0, e.err});
          chk("latency", cnt, e.lat);
          chk("req_cycles", reqc, e.lat - 1);
        end
        cnt  = 0;
        reqc = 0;
      end
    end
  end

  initial begin
    rst          = 1'b0;
    dataAddr     = '0;
    dataOut      = '0;
    dataMask     = '0;
    dataWe       = 1'b0;
    dataRe       = 1'b0;
    bus.memAck   = 1'b0;
    bus.memRdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dataIn", dataIn, 32'h0);
    chk("rst_busErr", {31'b0, busErr}, 32'd0);
    chk("rst_memReq", {31'b0, bus.memReq}, 32'd0);
    chk("rst_memAddr", bus.memAddr, 32'h0);
    chk("rst_memWdata", bus.memWdata, 32'h0);
    chk("rst_memBe", {28'b0, bus.memBe}, 32'h0);
    chk("rst_memValid", {31'b0, memValid}, 32'd1);
    rst = 1'b1;
    repeat (10) @(posedge clk);

    txn(1'b0, 1'b1, 32'h0000_1006, 32'h0, 4'h0, 0, 32'h1234_5678);
    idle(2);
    txn(1'b1, 1'b0, 32'h40, 32'h0000_AB00, 4'b0010, 3, 32'h77);
    idle(1);
    txn(1'b0, 1'b1, 32'h80, 32'h0, 4'h0, 99, 32'h0);
    idle(1);
    txn(1'b0, 1'b1, 32'hC4, 32'h0, 4'h0, TO - 1, 32'h5);
    txn(1'b1, 1'b1, 32'h103, 32'h55AA_0000, 4'b1100, 1, 32'h9);
    idle(2);

    // Reset while the bus transaction is outstanding
    @(posedge clk); #1;
    dataRe   = 1'b1;
    dataAddr = 32'h200;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst    = 1'b0;
    dataRe = 1'b0;
    #1;
    chk("async_rst_memReq", {31'b0, bus.memReq}, 32'd0);
    chk("async_rst_dataIn", dataIn, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    bus.memAck   = 1'b1;
    bus.memRdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    bus.memAck = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_dataIn", dataIn, 32'h0);
    txn(1'b0, 1'b1, 32'h300, 32'h0, 4'h0, 0, 32'hCAFE_0001);
    txn(1'b1, 1'b0, 32'h304, 32'h1111_2222, 4'h3, 2, 32'h0);
    idle(1);

    for (int i = 0; i < 150; i++) begin
      logic        we;
      logic        re;
      logic [31:0] a;
      we = 1'($urandom % 2);
      re = we ? 1'($urandom % 2) : 1'b1;
      a  = $urandom;
      txn(we, re, a, $urandom, 4'($urandom), $urandom_range(0, 6),
          $urandom);
      if ($urandom % 2 == 0) idle($urandom_range(0, 3));
    end
    idle(3);
    chk("queue_drained", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder for the core's data-memory port. It takes the core's MEM-stage request (dataAddr/dataOut/dataWe plus a read strobe), runs one transaction on a simple req/ack data bus with wait states, and returns dataIn and memValid.
- The core's hazard unit stalls while memValid is low.
- It sits between the core and the data SRAM or peripheral interconnect, and applies a timeout so a hung target cannot stall the core forever.

Parameters:
- TIMEOUT, 16, number of BUS cycles without memAck before an error response is forced; 0 disables the timeout.
- ERR_DATA, 32'hDEADBEEF, read data returned on a timeout.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- dataAddr  input  32  byte address from the core's MEM stage.
- dataOut  input  32  lane-aligned write data from the core.
- dataMask  input  4  byte enables for a write.
- dataWe  input  1  write request.
- dataRe  input  1  read request (the core's MEM-stage mem2reg).
- dataIn  output  32  read data to the core.
- memValid  output  1  high means the MEM stage may advance.
- busErr  output  1  one-cycle pulse when a transaction ends by timeout.
- memReq  output  1  bus request.
- memWe  output  1  bus write.
- memAddr  output  32  word-aligned bus address.
- memWdata  output  32  bus write data.
- memBe  output  4  bus byte enables.
- memRdata  input  32  bus read data, valid while memAck is high.
- memAck  input  1  bus acknowledge.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, timeout counter=0.
  - memReq, memWe, memAddr, memWdata, memBe, dataIn and busErr all go to 0.
  - memValid follows the IDLE rule below.
- Request: req = dataWe | dataRe. If both are high, the cycle is a write; dataIn returns 0 for it.
- State IDLE:
  - memValid = ~req, combinationally.
  - If req, at the next edge: go to BUS, latch the bus outputs, set memReq=1, clear the counter.
  - Latched bus outputs: memAddr = {dataAddr[31:2],2'b00}; memWe = dataWe; memWdata = dataOut; memBe = dataWe ? dataMask : 4'hF.
  - memAck while in IDLE is ignored.
- State BUS:
  - memValid=0.
  - memReq, memWe, memAddr, memWdata and memBe are held stable until the edge that samples memAck=1.
  - On memAck=1: go to DONE, memReq=0, dataIn <= memWe ? 0 : memRdata.
  - Otherwise, if TIMEOUT!=0 and counter==TIMEOUT-1: go to DONE, memReq=0, dataIn <= memWe ? 0 : ERR_DATA, busErr <= 1.
  - Otherwise the counter increments; it saturates and does not wrap.
  - If memAck and the timeout coincide, the ack wins and busErr stays 0.
- State DONE:
  - Lasts exactly 1 cycle.
  - memValid=1; dataIn holds the captured value; busErr is high only if the transaction timed out.
  - Next edge: go to IDLE, busErr <= 0. dataIn keeps its value until the next transaction completes.
  - The request inputs are not sampled in DONE. The core advances at this edge, so IDLE sees the next instruction.
- Latency:
  - Request visible in cycle 0; memReq high from cycle 1.
  - With memAck in cycle 1+k, memValid is high in cycle 2+k.
  - Minimum MEM-stage occupancy is 3 cycles.
- Core contract: the core holds its request inputs stable while memValid=0. The block does not re-sample them after IDLE.
- Reset mid-transaction: memReq drops immediately (asynchronously) and state returns to IDLE. A late memAck after reset is ignored.

Test Plan:
- Idle: dataWe=dataRe=0 for 10 cycles -> memValid=1 constantly, memReq=0, busErr=0.
- Zero-wait read: dataRe=1, dataAddr=0x0000_1006; memAck=1 with memRdata=0x1234_5678 in the first BUS cycle -> memAddr=0x0000_1004, memBe=4'hF, memWe=0; memValid low for cycles 0-1 and high in cycle 2; dataIn=0x1234_5678.
- Write with 3 wait states: dataWe=1, dataAddr=0x40, dataOut=0x0000_AB00, dataMask=4'b0010; memAck after 3 cycles -> memWdata, memBe and memAddr stable across all BUS cycles; memValid high in cycle 5; dataIn=0.
- Timeout, TIMEOUT=4, read, memAck never asserted -> memReq high for exactly 4 cycles; DONE with dataIn=0xDEADBEEF, busErr=1 for one cycle, memValid=1.
- Ack coinciding with timeout (TIMEOUT=4, memAck in the 4th BUS cycle, memRdata=0x5) -> dataIn=0x5, busErr=0.
- Reset in BUS state: rst=0 for 1 cycle, then memAck pulses -> memReq=0 immediately, state IDLE, ack ignored, no memValid pulse from the stale ack; back-to-back requests after reset complete normally.
